hc595_rx: RTL and testbench
===========================

// Module: hc595_rx
// PURPOSE
//  Receive-side model of the 74HC595 serial link driving the 6-digit 7-seg display.
//  Oversamples shcp/stcp/ds/oe with sys_clk, shifts 14 bits per frame, latches them on stcp,
//  and presents parallel sel/seg plus a valid strobe.
//  Used as display-side emulator and as an in-system monitor of the 595 driver output.
// PARAMETERS
//  DATA_W       14  bits per frame (6 sel + 8 seg)
//  SYNC_STAGES  2   synchronizer depth on every serial input (>=2)
// PORTS
//  sys_clk     in   1  system clock, 50 MHz
//  sys_rst_n   in   1  reset, asynchronous, active-low
//  shcp        in   1  shift clock from link (async to sys_clk)
//  stcp        in   1  storage/latch clock from link
//  ds          in   1  serial data from link
//  oe          in   1  output enable from link, active-low
//  sel         out  6  latched digit select
//  seg         out  8  latched segment pattern
//  data_valid  out  1  1-cycle pulse: new frame latched
//  frame_err   out  1  last latched frame had bit count != DATA_W (macro only)
//  err_cnt     out  8  saturating count of bad frames (macro only)
// BEHAVIOUR
//  - Reset: sel=0, seg=0, data_valid=0, frame_err=0, err_cnt=0, shift reg=0, hold reg=0, bit_cnt=0.
//  - shcp, stcp, ds, oe all pass SYNC_STAGES flops (equal delay, keeps ds aligned to shcp).
//  - Rising edge = sync'd level 1 now, 0 previous cycle; one extra flop for edge detect.
//  - Link timing: shcp high >=1 and low >=1 sys_clk; ds stable 1 cycle either side of shcp rise.
//  - On shcp rise: sreg <= {ds_s, sreg[DATA_W-1:1]}; bit_cnt <= min(bit_cnt+1, 15).
//    First bit sent lands in sreg[0].
//  - On stcp rise: hold <= sreg (value BEFORE any same-cycle shift); bit_cnt <= 0 (or 1 if shcp rise
//    same cycle); data_valid=1 next cycle.
//  - Bit map: sel = hold[5:0]; seg[7-i] = hold[6+i], i=0..7 (seg bit-reversed on the wire).
//  - Latency: link stcp rise -> sel/seg/data_valid update = SYNC_STAGES+2 sys_clk.
//  - oe_s=1: sel=6'h00, seg=8'h00 (blank); hold reg keeps updating; outputs return to hold
//    contents the cycle after oe_s falls.
//  - FSM: IDLE (bit_cnt=0) -> SHIFT on shcp rise; SHIFT -> IDLE on stcp rise.
//    stcp rise in IDLE latches sreg unchanged (re-latch, counts as a 0-bit frame).
//  - More than DATA_W shifts: oldest bits fall out of sreg[0]; bit_cnt saturates at 15.
//  - Reset mid-frame: all state cleared; partial frame discarded; no data_valid.
// CONFIGURATION
//  HC595_RX_FRAME_CHECK_EN defined:
//   - on each stcp rise, frame_err <= (bit_cnt != DATA_W);
//   - err_cnt += frame_err, saturating at 8'hFF.
//  Not defined: frame_err and err_cnt tied to 0, bit_cnt checker logic removed;
//   FSM and bit_cnt still present.
// STRUCTURE
//  Package hc595_pkg: DATA_W=14, SEL_W=6, SEG_W=8, SEL_BLANK=6'h00, SEG_BLANK=8'h00,
//   rx_state_t {IDLE, SHIFT}.
//  Sub-module hc595_sync_edge: SYNC_STAGES synchronizer + rise detect.
//   Instantiated for shcp and stcp; ds and oe use its level output only.
// TESTING
//  1 Send sel=6'b000001, seg=8'hC0, 14 bits, stcp pulse
//    -> sel=6'h01, seg=8'hC0, single data_valid pulse SYNC_STAGES+2 cycles after stcp.
//  2 Back-to-back frames 6'h3F/8'hFF then 6'h20/8'h92
//    -> two valid pulses, outputs match each frame, frame_err=0.
//  3 (macro) 13 shifts then stcp -> frame_err=1, err_cnt=1; next good frame -> frame_err=0, err_cnt=1.
//  4 Latch frame 6'h02/8'hA4, drive oe=1 -> sel=0, seg=0; oe=0 -> 6'h02/8'hA4 restored, no valid pulse.
//  5 Assert sys_rst_n low after 7 bits, release, send full frame 6'h04/8'hB0
//    -> only that frame latched, err_cnt=0.
//  6 shcp and stcp rise same cycle after 14 bits
//    -> latched value excludes the coincident bit, bit_cnt=1 afterward.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared constants, FSM state type and wire-to-segment bit mapping for the 74HC595 link receiver.
package hc595_pkg;

    localparam int DATA_W = 14;
    localparam int SEL_W  = 6;
    localparam int SEG_W  = 8;

    localparam logic [SEL_W-1:0] SEL_BLANK = 6'h00;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

    // Segment byte travels bit-reversed behind the select field.
    function automatic logic [SEG_W-1:0] seg_from_hold(input logic [DATA_W-1:0] hold);
        logic [SEG_W-1:0] seg;
        seg = '0;
        for (int i = 0; i < SEG_W; i++) begin
            seg[SEG_W-1-i] = hold[SEL_W+i];
        end
        return seg;
    endfunction

endpackage

// File: rtl/hc595_sync_edge.sv
// Multi-stage synchronizer for one asynchronous link line, plus a rising-edge strobe.
module hc595_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/hc595_rx.sv
// Receive side of the 74HC595 display link: shifts serial frames, latches on stcp, drives sel/seg.
// Optional frame bit-count checker enabled by HC595_RX_FRAME_CHECK_EN.
//   state | meaning
//   IDLE  | no bits shifted since the last latch (bit count is zero)
//   SHIFT | at least one bit shifted into the current frame
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             ds,
    input  logic             oe,
    output logic [SEL_W-1:0] sel,
    output logic [SEG_W-1:0] seg,
    output logic             data_valid,
    output logic             frame_err,
    output logic [7:0]       err_cnt
);

    logic w_shcp_rise, w_stcp_rise, w_ds_s, w_oe_s;
    logic w_unused_shcp_lvl, w_unused_stcp_lvl, w_unused_ds_rise, w_unused_oe_rise;

    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shcp (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_d(shcp),
        .o_level(w_unused_shcp_lvl), .o_rise(w_shcp_rise)
    );
    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stcp (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_d(stcp),
        .o_level(w_unused_stcp_lvl), .o_rise(w_stcp_rise)
    );
    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_d(ds),
        .o_level(w_ds_s), .o_rise(w_unused_ds_rise)
    );
    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_d(oe),
        .o_level(w_oe_s), .o_rise(w_unused_oe_rise)
    );

    logic [DATA_W-1:0] r_sreg, r_hold;
    logic [3:0]        r_bit_cnt;
    logic              r_latch_pend;
    logic [SEL_W-1:0]  r_sel;
    logic [SEG_W-1:0]  r_seg;
    logic              r_valid;
    rx_state_t         r_state, w_state_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_shcp_rise) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_stcp_rise && !w_shcp_rise) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch takes sreg as it was before any coincident shift.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sreg       <= '0;
            r_hold       <= '0;
            r_bit_cnt    <= 4'd0;
            r_latch_pend <= 1'b0;
        end else begin
            r_latch_pend <= w_stcp_rise;
            if (w_shcp_rise) r_sreg <= {w_ds_s, r_sreg[DATA_W-1:1]};
            if (w_stcp_rise) r_hold <= r_sreg;
            if (w_stcp_rise) begin
                r_bit_cnt <= w_shcp_rise ? 4'd1 : 4'd0;
            end else if (w_shcp_rise && r_bit_cnt != 4'hF) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sel   <= SEL_BLANK;
            r_seg   <= SEG_BLANK;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_latch_pend;
            if (w_oe_s) begin
                r_sel <= SEL_BLANK;
                r_seg <= SEG_BLANK;
            end else begin
                r_sel <= r_hold[SEL_W-1:0];
                r_seg <= seg_from_hold(r_hold);
            end
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign data_valid = r_valid;

`ifdef HC595_RX_FRAME_CHECK_EN
    logic       r_frame_err;
    logic [7:0] r_err_cnt;
    logic       w_bad_frame;

    assign w_bad_frame = (r_bit_cnt != 4'(DATA_W));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_err <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else if (w_stcp_rise) begin
            r_frame_err <= w_bad_frame;
            if (w_bad_frame && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_err = 1'b0;
    assign err_cnt   = 8'h00;
`endif

endmodule

// File: tb/tb_hc595_rx.sv
// Randomized and directed bench for hc595_rx against a bit-history model of the 595 link.
module tb_hc595_rx;
    import hc595_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       shcp = 1'b0, stcp = 1'b0, ds = 1'b0, oe = 1'b0;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       data_valid, frame_err;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every bit shifted since reset; the register is simply the newest DATA_W of them.
    bit          hist[$];
    int          bits_since = 0;
    logic [13:0] m_hold = '0;
    logic        m_ferr = 1'b0;
    int          m_ecnt = 0;

    always #10 sys_clk = ~sys_clk;

    hc595_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe),
        .sel(sel), .seg(seg), .data_valid(data_valid),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [13:0] model_sreg();
        logic [13:0] r;
        r = '0;
        for (int k = 0; k < 14; k++) begin
            if (k < hist.size()) r[13-k] = hist[hist.size()-1-k];
        end
        return r;
    endfunction

    function automatic logic [13:0] mk_word(input logic [5:0] s, input logic [7:0] g);
        logic [13:0] w;
        w[5:0] = s;
        for (int i = 0; i < 8; i++) w[6+i] = g[7-i];
        return w;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [13:0] w);
        logic [7:0] g;
        for (int i = 0; i < 8; i++) g[7-i] = w[6+i];
        return g;
    endfunction

    task automatic send_bit(input bit b);
        ds = b;
        tick(1);
        shcp = 1'b1;
        tick(1);
        shcp = 1'b0;
        tick(1);
        hist.push_back(b);
        bits_since++;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic check_frame_flags(input string tag);
`ifdef HC595_RX_FRAME_CHECK_EN
        chk({tag, " frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(m_ecnt));
`else
        chk({tag, " frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
`endif
    endtask

    task automatic check_outputs(input string tag);
        if (oe) begin
            chk({tag, " sel"}, 32'(sel), 32'd0);
            chk({tag, " seg"}, 32'(seg), 32'd0);
        end else begin
            chk({tag, " sel"}, 32'(sel), 32'(m_hold[5:0]));
            chk({tag, " seg"}, 32'(seg), 32'(exp_seg(m_hold)));
        end
    endtask

    // Pulse stcp (optionally together with a shcp rise) and check latency, pulse count and contents.
    task automatic latch(input bit coinc, input bit b, input string tag);
        int lat;
        int pulses;
        m_hold = model_sreg();
        m_ferr = (bits_since != DATA_W);
        if (m_ferr && m_ecnt < 255) m_ecnt++;
        bits_since = 0;
        if (coinc) begin
            ds = b;
            tick(1);
            shcp = 1'b1;
            hist.push_back(b);
            bits_since = 1;
        end
        stcp = 1'b1;
        lat = -1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 2) begin
                stcp = 1'b0;
                shcp = 1'b0;
            end
            if (data_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        chk({tag, " latency"}, lat, SYNC_STAGES + 2);
        chk({tag, " pulses"}, pulses, 1);
        check_outputs(tag);
        check_frame_flags(tag);
    endtask

    task automatic do_reset(input string tag);
        sys_rst_n = 1'b0;
        shcp = 1'b0;
        stcp = 1'b0;
        ds = 1'b0;
        tick(2);
        chk({tag, " rst sel"}, 32'(sel), 32'd0);
        chk({tag, " rst seg"}, 32'(seg), 32'd0);
        chk({tag, " rst valid"}, 32'(data_valid), 32'd0);
        chk({tag, " rst frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, " rst err_cnt"}, 32'(err_cnt), 32'd0);
        hist.delete();
        bits_since = 0;
        m_hold = '0;
        m_ferr = 1'b0;
        m_ecnt = 0;
        sys_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic oe_blank_check(input string tag);
        int pulses;
        pulses = 0;
        oe = 1'b1;
        for (int k = 0; k < SYNC_STAGES + 3; k++) begin
            tick(1);
            if (data_valid) pulses++;
        end
        check_outputs({tag, " blank"});
        oe = 1'b0;
        for (int k = 0; k < SYNC_STAGES + 3; k++) begin
            tick(1);
            if (data_valid) pulses++;
        end
        check_outputs({tag, " restore"});
        chk({tag, " no valid"}, pulses, 0);
    endtask

    initial begin
        logic [31:0] rnd;
        int          n;

        do_reset("t0");

        send_bits(32'(mk_word(6'h01, 8'hC0)), 14);
        latch(1'b0, 1'b0, "t1");
        chk("t1 sel const", 32'(sel), 32'h01);
        chk("t1 seg const", 32'(seg), 32'hC0);

        send_bits(32'(mk_word(6'h3F, 8'hFF)), 14);
        latch(1'b0, 1'b0, "t2a");
        send_bits(32'(mk_word(6'h20, 8'h92)), 14);
        latch(1'b0, 1'b0, "t2b");
        chk("t2b seg const", 32'(seg), 32'h92);

        send_bits(32'(mk_word(6'h15, 8'h5A)), 13);
        latch(1'b0, 1'b0, "t3a");
        send_bits(32'(mk_word(6'h2A, 8'h3C)), 14);
        latch(1'b0, 1'b0, "t3b");

        send_bits(32'(mk_word(6'h02, 8'hA4)), 14);
        latch(1'b0, 1'b0, "t4");
        oe_blank_check("t4");
        chk("t4 seg const", 32'(seg), 32'hA4);

        send_bits(32'(mk_word(6'h3B, 8'h77)), 7);
        do_reset("t5");
        send_bits(32'(mk_word(6'h04, 8'hB0)), 14);
        latch(1'b0, 1'b0, "t5");
        chk("t5 sel const", 32'(sel), 32'h04);

        send_bits(32'(mk_word(6'h11, 8'h33)), 14);
        latch(1'b1, 1'b1, "t6a");
        send_bits(32'(mk_word(6'h0E, 8'hE1)), 13);
        latch(1'b0, 1'b0, "t6b");

        send_bits($urandom(), 20);
        latch(1'b0, 1'b0, "t7 overflow");

        latch(1'b0, 1'b0, "t8 relatch");

        for (int it = 0; it < 24; it++) begin
            rnd = $urandom();
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 18)) : 14;
            send_bits(rnd, n);
            latch(($urandom_range(0, 5) == 0), rnd[31], "rnd");
            if ($urandom_range(0, 3) == 0) oe_blank_check("rnd oe");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
